demux4_reg: RTL
===============

// Module: demux4_reg
// PURPOSE
//  Registered 1->4 demultiplexer: the distribution-side counterpart of the 4->1 mux.
//  - Accepts one WIDTH-bit word per cycle on a valid/ready input and steers it, by a 2-bit
//    select, into one of four output channels.
//  - Each output channel has its own one-entry holding register with valid/ready.
//  - Feeds per-operand consumers of the ALU datapath from a single shared source.
// PARAMETERS
//  WIDTH   8   data word width in bits (>=1)
// PORTS
//  clk        in   1         clock, rising-edge
//  rst_n      in   1         asynchronous reset, active-low
//  in_valid   in   1         input word present
//  in_ready   out  1         block can accept input this cycle
//  in_data    in   WIDTH     input word
//  in_sel     in   2         destination channel 0..3 (ignored when DEMUX4_AUTOSEL_EN defined)
//  out_valid  out  4         bit k: channel k holds a word
//  out_ready  in   4         bit k: consumer k takes channel k word this cycle
//  out_data   out  4*WIDTH   channel k word at [k*WIDTH +: WIDTH]
//  cur_sel    out  2         effective destination this cycle (in_sel, or auto pointer)
// BEHAVIOUR
//  - Reset (async assert, sync-released use): out_valid=4'b0000, out_data=0, cur_sel=0;
//    in_ready follows combinationally (=1 after reset).
//  - Effective channel s = cur_sel.
//  - in_ready = !out_valid[s] || out_ready[s]. Combinational from out_valid/out_ready/cur_sel.
//    No dependence on in_valid.
//  - Accept: in_valid && in_ready. On the next edge:
//    - out_data[s] <= in_data
//    - out_valid[s] <= 1
//  - Drain: out_valid[k] && out_ready[k] clears out_valid[k] unless the same channel is
//    reloaded that cycle. Simultaneous drain+load of one channel keeps valid=1 with new data
//    (full throughput, no bubble).
//  - Latency: accepted word visible on out_data/out_valid exactly 1 cycle later.
//  - Channels not selected are untouched; any number may drain in the same cycle.
//  - Full channel with out_ready=0: in_ready=0 and input stalls; in_data/in_sel must be held
//    by the source.
//  - out_data[k] is held stable while out_valid[k]=1 && out_ready[k]=0.
//    Stale data is retained after drain (not cleared).
//  - Reset mid-operation: all held words are discarded and out_valid is cleared immediately
//    (async).
//  - in_valid=0: no state change except drains.
// CONFIGURATION
//  - DEMUX4_AUTOSEL_EN defined: in_sel ignored; round-robin FSM with states CH0->CH1->CH2->CH3
//    ->CH0, reset state CH0.
//    - Advances one state on each accepted transfer only; holds on a stall.
//    - cur_sel = state.
//  - DEMUX4_AUTOSEL_EN undefined: no FSM register; cur_sel = in_sel.
//    The in_sel port is still present.
// STRUCTURE
//  - Package demux4_pkg:
//    - localparam NUM_CH = 4
//    - typedef logic [1:0] ch_sel_t
//    - typedef enum ch_sel_t {CH0, CH1, CH2, CH3} rr_state_e
//  - Sub-module demux4_slot (WIDTH): one-entry register slot.
//    - Ports: clk, rst_n, load, load_data, ready, valid, data.
//    - Instantiated 4x by generate; the top holds only select decode, in_ready and the
//      optional FSM.
// TESTING
//  1. Reset, WIDTH=8, all out_ready=1, in_sel=2, in_data=8'hA5, in_valid=1 for 1 cycle
//     -> next cycle out_valid=4'b0100, out_data[23:16]=8'hA5, in_ready stays 1.
//  2. out_ready=0, send 8'h11 to ch1, then 8'h22 to ch1
//     -> second cycle in_ready=0, out_data[15:8] stays 8'h11.
//     Set out_ready[1]=1 -> 8'h22 loaded next cycle, out_valid[1] stays 1.
//  3. Back-to-back 8'h01,8'h02,8'h03,8'h04 to ch0..ch3, out_ready=0
//     -> out_valid=4'b1111 after 4 cycles, each out_data lane matches.
//  4. Fill ch3, assert rst_n=0 mid-stream without a clock edge
//     -> out_valid=0 immediately, in_ready=1.
//  5. DEMUX4_AUTOSEL_EN, in_sel=0 held, 6 accepted words 8'h10..8'h15, out_ready=1
//     -> cur_sel sequence 0,1,2,3,0,1.
//     With ch2 stalled (out_ready[2]=0, full), cur_sel holds at 2 and in_ready=0.

Source files
------------

// File: rtl/demux4_pkg.sv
// Shared types for the registered 1->4 demultiplexer.
// Channel select type and round-robin state encoding.
package demux4_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_sel_t;

  typedef enum ch_sel_t {
    CH0,
    CH1,
    CH2,
    CH3
  } rr_state_e;

endpackage

// File: rtl/demux4_slot.sv
// One-entry output holding register with valid/ready.
// A load in the same cycle as a drain keeps the slot full.
module demux4_slot
  import demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Stale data is kept after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/demux4_reg.sv
// Registered 1->4 demultiplexer with per-channel holding slots.
// Define DEMUX4_AUTOSEL_EN for round-robin channel selection.
module demux4_reg
  import demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [1:0]            in_sel,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [1:0]            cur_sel
);

  logic              accept;
  logic [NUM_CH-1:0] load;

  assign in_ready = !out_valid[cur_sel] || out_ready[cur_sel];
  assign accept   = in_valid && in_ready;

`ifdef DEMUX4_AUTOSEL_EN
  rr_state_e state_q;
  rr_state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        CH0: state_d = CH1;
        CH1: state_d = CH2;
        CH2: state_d = CH3;
        CH3: state_d = CH0;
        default: state_d = CH0;
      endcase
    end
  end

  assign cur_sel = state_q;
`else
  assign cur_sel = in_sel;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = accept && (cur_sel == ch_sel_t'(k));

    demux4_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule
